// File: rtl/cic_decim_param.sv
// cic_decim_param: parametrised CIC decimator with valid gating and runtime shift.
// Define CIC_ROUND_SAT_EN for round-half-up plus saturation (one extra cycle).
module cic_decim_param #(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 8,
  parameter int STAGES  = 3,
  parameter int DIFF_M  = 1,
  parameter int RATIO_W = 16,
  parameter int ACC_W   = IN_W + STAGES * (RATIO_W + 1),
  parameter int SH_W    = $clog2(ACC_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RATIO_W-1:0]      decimation_ratio,
  input  logic [SH_W-1:0]         shift,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  d_in,
  output logic signed [OUT_W-1:0] d_out,
  output logic                    out_valid,
  output logic                    d_clk
);

  localparam logic [SH_W-1:0] SH_MAX = SH_W'(ACC_W - OUT_W);

  logic signed [ACC_W-1:0] integ_q [STAGES];
  logic signed [ACC_W-1:0] comb_q  [STAGES+1];
  logic signed [ACC_W-1:0] dly_q   [STAGES][DIFF_M];
  logic [STAGES:0]         cv_q;

  logic [RATIO_W-1:0] r_q, r_d, cnt_q, cnt_d, r_cur;
  logic               init_q, ev, ev_q;
  logic [SH_W-1:0]    sh_c;

  always_comb begin
    r_d   = (decimation_ratio <= RATIO_W'(1)) ? RATIO_W'(1)
                                              : decimation_ratio;
    r_cur = init_q ? r_q : r_d;
    ev    = in_valid && (cnt_q == r_cur - RATIO_W'(1));
    cnt_d = ev ? '0 : cnt_q + RATIO_W'(1);
    sh_c  = (shift > SH_MAX) ? SH_MAX : shift;
  end

  // Ratio re-latches only at a frame boundary (or the first live edge).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= RATIO_W'(1);
      cnt_q  <= '0;
      init_q <= 1'b0;
      ev_q   <= 1'b0;
    end else begin
      init_q <= 1'b1;
      ev_q   <= ev;
      if (!init_q || ev) r_q <= r_d;
      if (in_valid) cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) integ_q[k] <= '0;
    end else if (in_valid) begin
      integ_q[0] <= integ_q[0]
                  + {{(ACC_W-IN_W){d_in[IN_W-1]}}, d_in};
      for (int k = 1; k < STAGES; k++)
        integ_q[k] <= integ_q[k] + integ_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cv_q <= '0;
      for (int k = 0; k <= STAGES; k++) comb_q[k] <= '0;
      for (int k = 0; k < STAGES; k++)
        for (int j = 0; j < DIFF_M; j++) dly_q[k][j] <= '0;
    end else begin
      cv_q[0] <= ev_q;
      if (ev_q) comb_q[0] <= integ_q[STAGES-1];
      for (int k = 1; k <= STAGES; k++) begin
        cv_q[k] <= cv_q[k-1];
        if (cv_q[k-1]) begin
          comb_q[k]   <= comb_q[k-1] - dly_q[k-1][DIFF_M-1];
          dly_q[k-1][0] <= comb_q[k-1];
          for (int j = 1; j < DIFF_M; j++)
            dly_q[k-1][j] <= dly_q[k-1][j-1];
        end
      end
    end
  end

`ifdef CIC_ROUND_SAT_EN
  logic [ACC_W:0]              half;
  logic signed [ACC_W:0]       rnd_d, rs_q;
  logic signed [OUT_W-1:0]     sat_d;
  logic                        rv_q;

  always_comb begin
    half = '0;
    if (sh_c != '0) half[sh_c - SH_W'(1)] = 1'b1;
    rnd_d = $signed({comb_q[STAGES][ACC_W-1], comb_q[STAGES]})
          + $signed(half);
    sat_d = rs_q[OUT_W-1:0];
    // Any disagreement among bits above the slice means out of range.
    if (rs_q[ACC_W:OUT_W-1] != {(ACC_W-OUT_W+2){rs_q[ACC_W]}})
      sat_d = rs_q[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                          : {1'b0, {(OUT_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_q      <= '0;
      rv_q      <= 1'b0;
      d_out     <= '0;
      out_valid <= 1'b0;
      d_clk     <= 1'b0;
    end else begin
      rv_q      <= cv_q[STAGES];
      if (cv_q[STAGES]) rs_q <= rnd_d >>> sh_c;
      out_valid <= rv_q;
      if (rv_q) d_out <= sat_d;
      d_clk     <= out_valid;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out     <= '0;
      out_valid <= 1'b0;
      d_clk     <= 1'b0;
    end else begin
      out_valid <= cv_q[STAGES];
      if (cv_q[STAGES]) d_out <= comb_q[STAGES][sh_c +: OUT_W];
      d_clk     <= out_valid;
    end
  end
`endif

endmodule

// File: tb/tb_cic_decim_param.sv
// tb_cic_decim_param: directed + random checks of cic_decim_param against
// an arithmetic model (running sums, binomial comb, slice/round/saturate).
module tb_cic_decim_param;
  localparam int IN_W    = 8;
  localparam int OUT_W   = 8;
  localparam int STAGES  = 3;
  localparam int DIFF_M  = 1;
  localparam int RATIO_W = 16;
  localparam int ACC_W   = IN_W + STAGES * (RATIO_W + 1);
  localparam int SH_W    = $clog2(ACC_W);
`ifdef CIC_ROUND_SAT_EN
  localparam int LAT = STAGES + 3;
`else
  localparam int LAT = STAGES + 2;
`endif
  localparam longint MASK = (longint'(1) << ACC_W) - 1;

  logic                    clk;
  logic                    rst;
  logic [RATIO_W-1:0]      decimation_ratio;
  logic [SH_W-1:0]         shift;
  logic                    in_valid;
  logic signed [IN_W-1:0]  d_in;
  logic signed [OUT_W-1:0] d_out;
  logic                    out_valid;
  logic                    d_clk;

  cic_decim_param #(
    .IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES),
    .DIFF_M(DIFF_M), .RATIO_W(RATIO_W)
  ) dut (
    .clk(clk), .rst(rst),
    .decimation_ratio(decimation_ratio), .shift(shift),
    .in_valid(in_valid), .d_in(d_in),
    .d_out(d_out), .out_valid(out_valid), .d_clk(d_clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     t;
    longint y;
  } exp_t;

  longint           mi [STAGES];
  longint           hist [$];
  exp_t             q [$];
  int               mcnt, rlat, cyc;
  bit               init, prev_ov;
  logic signed [7:0] last_exp;
  int               checks, errors;

  function automatic longint wrapv(longint v);
    longint r;
    r = v & MASK;
    if (r[ACC_W-1]) r = r | ~MASK;
    return r;
  endfunction

  function automatic int eff(int r);
    return (r <= 1) ? 1 : r;
  endfunction

  // Comb cascade as the binomial expansion of (1 - z^-M)^STAGES.
  function automatic longint comb_out();
    longint y;
    longint c;
    y = 0;
    c = 1;
    for (int j = 0; j <= STAGES; j++) begin
      longint x;
      x = (j * DIFF_M < hist.size()) ? hist[j * DIFF_M] : 0;
      y = (j % 2 == 1) ? y - c * x : y + c * x;
      c = c * (STAGES - j) / (j + 1);
    end
    return wrapv(y);
  endfunction

  function automatic logic signed [7:0] slice(longint y, int sh);
    int     shc;
    longint v;
    shc = (sh > ACC_W - OUT_W) ? ACC_W - OUT_W : sh;
`ifdef CIC_ROUND_SAT_EN
    v = y + ((shc > 0) ? (longint'(1) << (shc - 1)) : longint'(0));
    v = v >>> shc;
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
`else
    v = y >>> shc;
`endif
    return v[7:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < STAGES; k++) mi[k] = 0;
    hist.delete();
    q.delete();
    mcnt = 0;
    rlat = 1;
    init = 0;
    prev_ov = 0;
    last_exp = 0;
  endtask

  task automatic model_edge(bit v, logic signed [7:0] d);
    int rcur;
    bit ev;
    rcur = init ? rlat : eff(int'(decimation_ratio));
    ev = v && (mcnt == rcur - 1);
    if (!init || ev) rlat = eff(int'(decimation_ratio));
    init = 1;
    if (v) begin
      for (int k = STAGES - 1; k >= 1; k--) mi[k] = wrapv(mi[k] + mi[k-1]);
      mi[0] = wrapv(mi[0] + longint'(d));
      mcnt = ev ? 0 : mcnt + 1;
    end
    if (ev) begin
      hist.push_front(mi[STAGES-1]);
      if (hist.size() > STAGES * DIFF_M + 1) void'(hist.pop_back());
      q.push_back('{cyc + LAT, comb_out()});
    end
  endtask

  task automatic chk(string tag, logic signed [63:0] obs,
                     logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit ov_e;
    ov_e = 0;
    if (q.size() > 0 && q[0].t == cyc) begin
      last_exp = slice(q[0].y, int'(shift));
      void'(q.pop_front());
      ov_e = 1;
    end
    chk("out_valid", {63'd0, out_valid}, {63'd0, ov_e});
    chk("d_out", d_out, last_exp);
    chk("d_clk", {63'd0, d_clk}, {63'd0, prev_ov});
    prev_ov = ov_e;
  endtask

  task automatic step(bit v, logic signed [7:0] d);
    in_valid = v;
    d_in = d;
    @(posedge clk);
    cyc++;
    if (rst) model_edge(v, d);
    #1;
    check_outputs();
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + 3; i++) step(1'b0, 8'sd0);
  endtask

  // Reset asserted asynchronously between edges, with in_valid toggling.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid", {63'd0, out_valid}, 64'sd0);
    chk("rst_d_out", d_out, 64'sd0);
    chk("rst_d_clk", {63'd0, d_clk}, 64'sd0);
    for (int i = 0; i < 4; i++) step(i[0], 8'($urandom));
    rst = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    d_in = '0;
    decimation_ratio = 16'd4;
    shift = 6'd6;
    model_reset();
    #12;

    // Unity DC gain: R=4, shift=6, constant 10
    do_reset();
    for (int i = 0; i < 60; i++) step(1'b1, 8'sd10);
    chk("unity_settled", d_out, 64'sd10);
    drain();

    // Ratio change mid-frame: 4 -> 8
    decimation_ratio = 16'd4;
    do_reset();
    step(1'b1, 8'sd20);
    step(1'b1, 8'sd20);
    decimation_ratio = 16'd8;
    for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom));
    drain();

    // Gated input: every 3rd cycle, R=2, shift=3, constant -5
    decimation_ratio = 16'd2;
    shift = 6'd3;
    do_reset();
    for (int i = 0; i < 90; i++) step(i % 3 == 0, -8'sd5);
    chk("gated_settled", d_out, -64'sd5);
    drain();

    // Back-to-back: ratio 0 means R=1
    decimation_ratio = 16'd0;
    shift = 6'd0;
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom));
    drain();

    // Random ratio, gating, data and shift (incl. clamped shifts)
    for (int r = 0; r < 8; r++) begin
      shift = 6'($urandom_range(0, 63));
      decimation_ratio = 16'($urandom_range(0, 7));
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 19) == 0)
          decimation_ratio = 16'($urandom_range(0, 7));
        step($urandom_range(0, 3) != 0, 8'($urandom));
      end
      drain();
    end

    // Reset while results are in flight: nothing may emerge
    decimation_ratio = 16'd1;
    shift = 6'd2;
    for (int i = 0; i < 3; i++) step(1'b1, 8'sd50);
    do_reset();
    drain();

    // Legacy: R=12500, shift=41, +100 then -100
    decimation_ratio = 16'd12500;
    shift = 6'd41;
    do_reset();
    for (int i = 0; i < 25000; i++) step(1'b1, 8'sd100);
    for (int i = 0; i < 12500; i++) step(1'b1, -8'sd100);
    drain();

    // Full-scale negative input with large ratio
    decimation_ratio = 16'd4000;
    shift = 6'd36;
    do_reset();
    for (int i = 0; i < 16000; i++) step(1'b1, -8'sd128);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
